// File: rtl/periph_rr_arbiter_id.sv
// Round-robin N:1 peripheral arbiter with request locking, per-master outstanding
// limits and ID-tagged response routing back to the issuing master.
module periph_rr_arbiter_id #(
    parameter int unsigned NB_MASTER       = 4,
    parameter int unsigned ADDR_WIDTH      = 32,
    parameter int unsigned DATA_WIDTH      = 32,
    parameter int unsigned ID_WIDTH        = 8,
    parameter int unsigned BE_WIDTH        = DATA_WIDTH / 8,
    parameter int unsigned MAX_OUTSTANDING = 4,
    localparam int unsigned IDX_W          = $clog2(NB_MASTER),
    localparam int unsigned OID_W          = ID_WIDTH + IDX_W
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic [NB_MASTER-1:0]                 m_req_i,
    input  logic [NB_MASTER-1:0][ADDR_WIDTH-1:0] m_add_i,
    input  logic [NB_MASTER-1:0]                 m_we_n_i,
    input  logic [NB_MASTER-1:0][DATA_WIDTH-1:0] m_wdata_i,
    input  logic [NB_MASTER-1:0][BE_WIDTH-1:0]   m_be_i,
    input  logic [NB_MASTER-1:0][ID_WIDTH-1:0]   m_id_i,
    output logic [NB_MASTER-1:0]                 m_gnt_o,
    output logic [NB_MASTER-1:0]                 m_r_valid_o,
    output logic                                 m_r_opc_o,
    output logic [ID_WIDTH-1:0]                  m_r_id_o,
    output logic [DATA_WIDTH-1:0]                m_r_rdata_o,
    output logic                                 s_req_o,
    output logic [ADDR_WIDTH-1:0]                s_add_o,
    output logic                                 s_we_n_o,
    output logic [DATA_WIDTH-1:0]                s_wdata_o,
    output logic [BE_WIDTH-1:0]                  s_be_o,
    output logic [OID_W-1:0]                     s_id_o,
    input  logic                                 s_gnt_i,
    input  logic                                 s_r_valid_i,
    input  logic                                 s_r_opc_i,
    input  logic [OID_W-1:0]                     s_r_id_i,
    input  logic [DATA_WIDTH-1:0]                s_r_rdata_i,
    output logic                                 err_o
);

    localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

    logic                             rr_en_unused;
    logic [IDX_W-1:0]                 rr_q, rr_d;
    logic                             lock_q, lock_d;
    logic [IDX_W-1:0]                 lock_idx_q, lock_idx_d;
    logic [NB_MASTER-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic                             err_q, err_d;

    logic [NB_MASTER-1:0]             elig_c;
    logic [IDX_W-1:0]                 win_c;
    logic [IDX_W-1:0]                 cand_c;
    logic                             found_c;
    logic                             lock_hold_c;
    logic                             lock_drop_c;
    logic                             hs_c;
    logic                             rsp_err_c;
    logic [IDX_W-1:0]                 rsp_idx_c;

    assign rr_en_unused = 1'b0;
    assign rsp_idx_c    = s_r_id_i[OID_W-1:ID_WIDTH];

    // Winner selection: a held lock wins outright, otherwise scan from rr_q.
    always_comb begin
        elig_c      = '0;
        win_c       = '0;
        cand_c      = '0;
        found_c     = 1'b0;
        lock_hold_c = lock_q & m_req_i[lock_idx_q];
        lock_drop_c = lock_q & ~m_req_i[lock_idx_q];
        for (int unsigned k = 0; k < NB_MASTER; k++) begin
            elig_c[k] = m_req_i[k] && (cnt_q[k] < CNT_W'(MAX_OUTSTANDING));
        end
        if (lock_hold_c) begin
            win_c   = lock_idx_q;
            found_c = 1'b1;
        end else begin
            for (int unsigned i = 0; i < NB_MASTER; i++) begin
                cand_c = rr_q + IDX_W'(i);
                if (!found_c && elig_c[cand_c]) begin
                    win_c   = cand_c;
                    found_c = 1'b1;
                end
            end
        end
    end

    assign hs_c      = found_c & s_gnt_i;
    assign s_req_o   = found_c;
    assign s_add_o   = m_add_i[win_c];
    assign s_we_n_o  = m_we_n_i[win_c];
    assign s_wdata_o = m_wdata_i[win_c];
    assign s_be_o    = m_be_i[win_c];
    assign s_id_o    = {win_c, m_id_i[win_c]};

    always_comb begin
        m_gnt_o = '0;
        if (hs_c) begin
            m_gnt_o[win_c] = 1'b1;
        end
    end

    // Responses are routed purely by the index field prepended at issue time.
    always_comb begin
        m_r_valid_o = '0;
        for (int unsigned k = 0; k < NB_MASTER; k++) begin
            m_r_valid_o[k] = s_r_valid_i && (rsp_idx_c == IDX_W'(k));
        end
    end

    assign m_r_id_o    = s_r_id_i[ID_WIDTH-1:0];
    assign m_r_opc_o   = s_r_opc_i;
    assign m_r_rdata_o = s_r_rdata_i;

    // Next-state for pointer, lock, outstanding counters and error pulse.
    always_comb begin
        rr_d       = rr_q;
        lock_d     = 1'b0;
        lock_idx_d = lock_idx_q;
        cnt_d      = cnt_q;
        rsp_err_c  = 1'b0;
        if (hs_c) begin
            rr_d = win_c + IDX_W'(1);
        end
        if (found_c && !s_gnt_i) begin
            lock_d     = 1'b1;
            lock_idx_d = win_c;
        end
        for (int unsigned k = 0; k < NB_MASTER; k++) begin
            if ((hs_c && (win_c == IDX_W'(k))) && !m_r_valid_o[k]) begin
                cnt_d[k] = cnt_q[k] + CNT_W'(1);
            end else if (m_r_valid_o[k] && !(hs_c && (win_c == IDX_W'(k)))) begin
                if (cnt_q[k] == '0) begin
                    rsp_err_c = 1'b1;
                end else begin
                    cnt_d[k] = cnt_q[k] - CNT_W'(1);
                end
            end
        end
        err_d = lock_drop_c | rsp_err_c | rr_en_unused;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rr_q       <= '0;
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_periph_rr_arbiter_id.sv
// Bench for periph_rr_arbiter_id: directed scenarios with literal expectations plus
// random traffic checked every cycle against a queue-based behavioural model.
module tb_periph_rr_arbiter_id;

    localparam int NB   = 4;
    localparam int MAXO = 2;

    logic              clk;
    logic              rst;
    logic [3:0]        m_req;
    logic [3:0][31:0]  m_add;
    logic [3:0]        m_we_n;
    logic [3:0][31:0]  m_wdata;
    logic [3:0][3:0]   m_be;
    logic [3:0][7:0]   m_id;
    logic [3:0]        m_gnt;
    logic [3:0]        m_r_valid;
    logic              m_r_opc;
    logic [7:0]        m_r_id;
    logic [31:0]       m_r_rdata;
    logic              s_req;
    logic [31:0]       s_add;
    logic              s_we_n;
    logic [31:0]       s_wdata;
    logic [3:0]        s_be;
    logic [9:0]        s_id;
    logic              s_gnt;
    logic              s_r_valid;
    logic              s_r_opc;
    logic [9:0]        s_r_id;
    logic [31:0]       s_r_rdata;
    logic              err;

    periph_rr_arbiter_id #(
        .NB_MASTER(4), .ADDR_WIDTH(32), .DATA_WIDTH(32), .ID_WIDTH(8),
        .BE_WIDTH(4), .MAX_OUTSTANDING(2)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .m_req_i(m_req), .m_add_i(m_add), .m_we_n_i(m_we_n), .m_wdata_i(m_wdata),
        .m_be_i(m_be), .m_id_i(m_id),
        .m_gnt_o(m_gnt), .m_r_valid_o(m_r_valid), .m_r_opc_o(m_r_opc),
        .m_r_id_o(m_r_id), .m_r_rdata_o(m_r_rdata),
        .s_req_o(s_req), .s_add_o(s_add), .s_we_n_o(s_we_n), .s_wdata_o(s_wdata),
        .s_be_o(s_be), .s_id_o(s_id),
        .s_gnt_i(s_gnt), .s_r_valid_i(s_r_valid), .s_r_opc_i(s_r_opc),
        .s_r_id_i(s_r_id), .s_r_rdata_i(s_r_rdata),
        .err_o(err)
    );

    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    // Model state: next-priority pointer, lock, and the issued-but-unanswered IDs per master.
    int         md_rr;
    bit         md_lock;
    int         md_lock_idx;
    logic [9:0] md_pend[4][$];
    bit         md_err_exp;
    bit         md_found;
    int         md_win;
    bit         md_drop;

    logic       obs_sreq;
    logic [3:0] obs_gnt;
    logic [9:0] obs_sid;
    logic [3:0] obs_rvalid;
    logic [7:0] obs_rid;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_clear();
        md_rr       = 0;
        md_lock     = 0;
        md_lock_idx = 0;
        md_err_exp  = 0;
        for (int k = 0; k < NB; k++) md_pend[k].delete();
    endfunction

    // Evaluate the model against the current inputs and compare every output.
    task automatic eval_cmp();
        logic [3:0] exp_gnt;
        logic [3:0] exp_rv;
        logic [1:0] w2;
        int         c;
        md_found = 0;
        md_win   = 0;
        md_drop  = md_lock && !m_req[md_lock_idx];
        if (md_lock && m_req[md_lock_idx]) begin
            md_found = 1;
            md_win   = md_lock_idx;
        end else begin
            for (int i = 0; i < NB; i++) begin
                c = (md_rr + i) % NB;
                if (!md_found && m_req[c] && md_pend[c].size() < MAXO) begin
                    md_found = 1;
                    md_win   = c;
                end
            end
        end
        w2      = 2'(md_win);
        exp_gnt = (md_found && s_gnt) ? 4'(1 << md_win) : 4'b0;
        exp_rv  = s_r_valid ? 4'(1 << s_r_id[9:8]) : 4'b0;
        chk("s_req", 64'(s_req), 64'(md_found));
        chk("m_gnt", 64'(m_gnt), 64'(exp_gnt));
        if (md_found) begin
            chk("s_id", 64'(s_id), 64'({w2, m_id[md_win]}));
            chk("s_add", 64'(s_add), 64'(m_add[md_win]));
            chk("s_we_n", 64'(s_we_n), 64'(m_we_n[md_win]));
            chk("s_wdata", 64'(s_wdata), 64'(m_wdata[md_win]));
            chk("s_be", 64'(s_be), 64'(m_be[md_win]));
        end
        chk("m_r_valid", 64'(m_r_valid), 64'(exp_rv));
        chk("m_r_id", 64'(m_r_id), 64'(s_r_id[7:0]));
        chk("m_r_opc", 64'(m_r_opc), 64'(s_r_opc));
        chk("m_r_rdata", 64'(m_r_rdata), 64'(s_r_rdata));
        chk("err", 64'(err), 64'(md_err_exp));
        obs_sreq   = s_req;
        obs_gnt    = m_gnt;
        obs_sid    = s_id;
        obs_rvalid = m_r_valid;
        obs_rid    = m_r_id;
    endtask

    // Advance the model across one clock edge using the inputs still applied.
    function automatic void model_update();
        bit hs;
        bit rsp_err;
        int ridx;
        hs      = md_found && s_gnt;
        ridx    = int'(s_r_id[9:8]);
        rsp_err = s_r_valid && md_pend[ridx].size() == 0 && !(hs && md_win == ridx);
        if (hs) begin
            md_rr = (md_win + 1) % NB;
            md_pend[md_win].push_back(s_id);
        end
        if (s_r_valid && md_pend[ridx].size() > 0) void'(md_pend[ridx].pop_front());
        md_lock = md_found && !s_gnt;
        if (md_lock) md_lock_idx = md_win;
        md_err_exp = md_drop || rsp_err;
    endfunction

    task automatic step(input logic [3:0] req, input logic gnt, input logic rv, input logic [9:0] rid);
        m_req     = req;
        s_gnt     = gnt;
        s_r_valid = rv;
        s_r_id    = rid;
        s_r_opc   = 1'($urandom);
        s_r_rdata = $urandom;
        for (int k = 0; k < NB; k++) begin
            m_add[k]   = $urandom;
            m_wdata[k] = $urandom;
            m_be[k]    = 4'($urandom);
            m_id[k]    = 8'($urandom);
        end
        m_we_n = 4'($urandom);
        #2;
        eval_cmp();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Reset asserted between edges, checked while held, released after the next edge.
    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_clear();
        eval_cmp();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    logic [9:0] rid_v;
    logic [3:0] req_v;
    int         pk;

    initial begin
        n_chk = 0; n_fail = 0;
        clk = 0; rst = 1;
        m_req = '0; m_add = '0; m_we_n = '0; m_wdata = '0; m_be = '0; m_id = '0;
        s_gnt = 1; s_r_valid = 0; s_r_opc = 0; s_r_id = '0; s_r_rdata = '0;
        model_clear();
        #2;
        chk("reset_s_req", 64'(s_req), 64'(0));
        chk("reset_m_gnt", 64'(m_gnt), 64'(0));
        chk("reset_err", 64'(err), 64'(0));
        @(posedge clk); #1;
        rst = 0;

        // All four requesting with a response each cycle: strict rotation 0..3.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            rid_v = {2'(i - 1), 8'h00};
            step(4'b1111, 1'b1, i > 0, rid_v);
            chk("rot_sid_idx", 64'(obs_sid[9:8]), 64'(i));
            chk("rot_gnt", 64'(obs_gnt), 64'(1 << i));
        end

        // Outstanding limit blocks master 0 until a response frees a slot.
        do_reset();
        step(4'b0001, 1'b1, 1'b0, 10'h0);
        chk("lim_req0", 64'(obs_sreq), 64'(1));
        step(4'b0001, 1'b1, 1'b0, 10'h0);
        chk("lim_req1", 64'(obs_sreq), 64'(1));
        step(4'b0001, 1'b1, 1'b0, 10'h0);
        chk("lim_blocked", 64'(obs_sreq), 64'(0));
        step(4'b0001, 1'b1, 1'b1, {2'd0, 8'h33});
        chk("lim_still_blocked", 64'(obs_sreq), 64'(0));
        step(4'b0001, 1'b1, 1'b0, 10'h0);
        chk("lim_regrant", 64'(obs_gnt), 64'(4'b0001));

        // Stalled target keeps the winner locked, then rotation continues.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            step(4'b0110, 1'b0, 1'b0, 10'h0);
            chk("lock_req", 64'(obs_sreq), 64'(1));
            chk("lock_win", 64'(obs_sid[9:8]), 64'(1));
        end
        step(4'b0110, 1'b1, 1'b0, 10'h0);
        chk("lock_gnt", 64'(obs_gnt), 64'(4'b0010));
        step(4'b0110, 1'b1, 1'b0, 10'h0);
        chk("lock_next", 64'(obs_sid[9:8]), 64'(2));

        // Unsolicited response routes correctly and flags an error.
        do_reset();
        step(4'b0000, 1'b1, 1'b1, {2'd3, 8'hA5});
        chk("rsp_valid", 64'(obs_rvalid), 64'(4'b1000));
        chk("rsp_id", 64'(obs_rid), 64'(8'hA5));
        chk("rsp_err", 64'(err), 64'(1));

        // Issue and response for the same master in one cycle cancel out.
        do_reset();
        step(4'b0100, 1'b1, 1'b0, 10'h0);
        step(4'b0100, 1'b1, 1'b1, {2'd2, 8'h11});
        chk("same_cyc_err", 64'(err), 64'(0));
        step(4'b0100, 1'b1, 1'b0, 10'h0);
        chk("same_cyc_one_left", 64'(obs_sreq), 64'(1));
        step(4'b0100, 1'b1, 1'b0, 10'h0);
        chk("same_cyc_full", 64'(obs_sreq), 64'(0));

        // Locked master withdraws: re-arbitrate same cycle and pulse error.
        do_reset();
        step(4'b0010, 1'b0, 1'b0, 10'h0);
        step(4'b0100, 1'b1, 1'b0, 10'h0);
        chk("drop_rearb", 64'(obs_sid[9:8]), 64'(2));
        chk("drop_err", 64'(err), 64'(1));

        // Reset in the middle of a lock with master 0 saturated.
        do_reset();
        step(4'b0001, 1'b1, 1'b0, 10'h0);
        step(4'b0001, 1'b1, 1'b0, 10'h0);
        step(4'b0011, 1'b0, 1'b0, 10'h0);
        chk("pre_rst_win", 64'(obs_sid[9:8]), 64'(1));
        do_reset();
        chk("rst_win0", 64'(obs_sid[9:8]), 64'(0));
        chk("rst_req", 64'(obs_sreq), 64'(1));
        step(4'b0011, 1'b1, 1'b0, 10'h0);
        chk("rst_gnt0", 64'(obs_gnt), 64'(4'b0001));

        // Random traffic against the model.
        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset();
            end else begin
                req_v = 4'($urandom);
                if (md_lock && $urandom_range(0, 9) != 0) req_v[md_lock_idx] = 1'b1;
                pk    = $urandom_range(0, 3);
                rid_v = {2'(pk), 8'($urandom)};
                if (md_pend[pk].size() > 0 && $urandom_range(0, 1) == 1) begin
                    step(req_v, $urandom_range(0, 3) != 0, 1'b1, md_pend[pk][0]);
                end else begin
                    step(req_v, $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, rid_v);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
